// File: rtl/usreg_pkg.sv
// Shared types and constants for the shift-register sequencer.
package usreg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

   localparam int         FRAME_LEN = 4;
   localparam logic [1:0] CNT_LAST  = 2'(FRAME_LEN - 1);

endpackage

// File: rtl/usreg_beh.sv
// Downstream 4-bit universal shift register driven by usreg_seq_ctrl.
module usreg_beh
   import usreg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] sel,
   input  logic [3:0] d,
   input  logic       serial,
   output logic [3:0] q
);

   logic [3:0] q_d;

   always_comb begin
      q_d = q;
      case (sel)
         SEL_SHR:  q_d = {serial, q[3:1]};
         SEL_SHL:  q_d = {q[2:0], serial};
         SEL_LOAD: q_d = d;
         default:  q_d = q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q <= '0;
      else      q <= q_d;
   end

endmodule

// File: rtl/usreg_seq_ctrl.sv
// Load/shift sequencer for a 4-bit universal shift register.
// Build option USREG_SEQ_ROTATE_EN: feed the outgoing bit back in (rotate) instead of fill_bit.
//
// state    | meaning
// ST_IDLE  | ready for a word, register held
// ST_LOAD  | parallel-load the latched word
// ST_SHIFT | shift out FRAME_LEN bits, counter 0..3
// ST_DONE  | one-cycle frame-end pulse
module usreg_seq_ctrl
   import usreg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   input  logic       in_dir,
   input  logic       fill_bit,
   input  logic       abort,
   input  logic [3:0] sr_q,
   output logic [1:0] sr_sel,
   output logic [3:0] sr_data,
   output logic       sr_serial,
   output logic       tx_bit,
   output logic       tx_valid,
   output logic       done
);

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] word_q, word_d;
   logic       dir_q, dir_d;
   logic       fill_q, fill_d;
   logic       accept;

   // abort wins over a coinciding offer in IDLE
   assign accept = in_valid && (state_q == ST_IDLE) && !abort;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      dir_d   = dir_q;
      fill_d  = fill_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (accept) begin
               word_d  = in_data;
               dir_d   = in_dir;
               fill_d  = fill_bit;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = abort ? ST_IDLE : ST_SHIFT;
         end
         ST_SHIFT: begin
            if (abort) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         dir_q   <= 1'b0;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         dir_q   <= dir_d;
         fill_q  <= fill_d;
      end
   end

   always_comb begin
      sr_sel   = SEL_HOLD;
      sr_data  = '0;
      in_ready = 1'b0;
      tx_valid = 1'b0;
      done     = 1'b0;
      case (state_q)
         ST_IDLE:  in_ready = 1'b1;
         ST_LOAD: begin
            if (!abort) begin
               sr_sel  = SEL_LOAD;
               sr_data = word_q;
            end
         end
         ST_SHIFT: begin
            tx_valid = 1'b1;
            if (!abort) sr_sel = dir_q ? SEL_SHL : SEL_SHR;
         end
         ST_DONE:  done = 1'b1;
         default:  sr_sel = SEL_HOLD;
      endcase
   end

   assign tx_bit = tx_valid & (dir_q ? sr_q[3] : sr_q[0]);

`ifdef USREG_SEQ_ROTATE_EN
   assign sr_serial = tx_bit;
`else
   assign sr_serial = tx_valid & fill_q;
`endif

endmodule
